// File: rtl/vga_ball_sched.sv
// vga_ball_sched: shares the vga_ball write port between the host
// and a once-per-frame bouncing-ball motion engine.
module vga_ball_sched #(
  parameter int X_MIN     = 4,
  parameter int X_MAX     = 155,
  parameter int Y_MIN     = 4,
  parameter int Y_MAX     = 55,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_chipselect,
  input  logic       host_write,
  input  logic [2:0] host_address,
  input  logic [7:0] host_writedata,
  input  logic       enable,
  input  logic       vga_vs,
  output logic       out_chipselect,
  output logic       out_write,
  output logic [2:0] out_address,
  output logic [7:0] out_writedata,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y
);

  typedef enum logic [1:0] {
    IDLE, CALC, WR_X, WR_Y
  } state_t;

  localparam logic signed [9:0] XMN = 10'(X_MIN);
  localparam logic signed [9:0] XMX = 10'(X_MAX);
  localparam logic signed [9:0] YMN = 10'(Y_MIN);
  localparam logic signed [9:0] YMX = 10'(Y_MAX);
  localparam logic [7:0] DLAST = 8'(FRAME_DIV - 1);

  state_t state, state_n;

  logic [7:0] x, y;
  logic signed [7:0] dx, dy;
  logic [7:0] cnt;
  logic vs_q;

  logic host_wr, fwd, abort;
  logic tick, fire;
  logic calc, eng_wr;
  logic [2:0] eng_addr;
  logic [7:0] eng_data;

  logic signed [9:0] nx, ny;
  logic [7:0] bx, by;
  logic signed [7:0] bdx, bdy;

  assign host_wr = host_chipselect & host_write;
  assign fwd     = host_wr & (host_address <= 3'd4);
  assign abort   = host_wr & (host_address >= 3'd3)
                 & (host_address <= 3'd6)
                 & (state != IDLE);

  assign tick = vs_q & ~vga_vs;
  assign fire = tick & (cnt == DLAST);

  assign ball_x = x;
  assign ball_y = y;

  // bounce arithmetic in 10-bit signed to see past both edges
  assign nx = $signed({2'b00, x})
            + $signed({{2{dx[7]}}, dx});
  assign ny = $signed({2'b00, y})
            + $signed({{2{dy[7]}}, dy});

  always_comb begin
    bx  = nx[7:0];
    bdx = dx;
    if (nx > XMX) begin
      bx  = XMX[7:0];
      bdx = -dx;
    end else if (nx < XMN) begin
      bx  = XMN[7:0];
      bdx = -dx;
    end
  end

  always_comb begin
    by  = ny[7:0];
    bdy = dy;
    if (ny > YMX) begin
      by  = YMX[7:0];
      bdy = -dy;
    end else if (ny < YMN) begin
      by  = YMN[7:0];
      bdy = -dy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (fire & enable) state_n = CALC;
      CALC: state_n = abort ? IDLE : WR_X;
      WR_X: begin
        if (abort)     state_n = IDLE;
        else if (!fwd) state_n = WR_Y;
      end
      WR_Y: if (abort | ~fwd) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    calc     = 1'b0;
    eng_wr   = 1'b0;
    eng_addr = 3'd3;
    eng_data = x;
    unique case (state)
      CALC: calc = ~abort;
      WR_X: eng_wr = ~fwd & ~abort;
      WR_Y: begin
        eng_wr   = ~fwd & ~abort;
        eng_addr = 3'd4;
        eng_data = y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q <= 1'b1;
      cnt  <= 8'd0;
    end else begin
      vs_q <= vga_vs;
      if (tick) cnt <= (cnt == DLAST) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x  <= 8'd80;
      y  <= 8'd30;
      dx <= 8'sd1;
      dy <= 8'sd1;
    end else begin
      if (host_wr && host_address == 3'd3) x <= host_writedata;
      else if (calc)                       x <= bx;
      if (host_wr && host_address == 3'd4) y <= host_writedata;
      else if (calc)                       y <= by;
      if (host_wr && host_address == 3'd5) dx <= host_writedata;
      else if (calc)                       dx <= bdx;
      if (host_wr && host_address == 3'd6) dy <= host_writedata;
      else if (calc)                       dy <= bdy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_chipselect <= 1'b0;
      out_write      <= 1'b0;
      out_address    <= 3'd0;
      out_writedata  <= 8'd0;
    end else begin
      unique case (1'b1)
        fwd: begin
          out_chipselect <= 1'b1;
          out_write      <= 1'b1;
          out_address    <= host_address;
          out_writedata  <= host_writedata;
        end
        eng_wr: begin
          out_chipselect <= 1'b1;
          out_write      <= 1'b1;
          out_address    <= eng_addr;
          out_writedata  <= eng_data;
        end
        default: begin
          out_chipselect <= 1'b0;
          out_write      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_ball_sched.sv
// tb_vga_ball_sched: directed plus random stimulus against a
// pending-write model, on FRAME_DIV = 1 and FRAME_DIV = 3 copies.
module tb_vga_ball_sched;

  localparam int XMN = 4;
  localparam int XMX = 155;
  localparam int YMN = 4;
  localparam int YMX = 55;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs = 1'b0;
  logic wr = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'd0;
  logic en = 1'b0;
  logic vs = 1'b1;

  logic o_cs [2];
  logic o_wr [2];
  logic [2:0] o_addr [2];
  logic [7:0] o_data [2];
  logic [7:0] o_bx [2];
  logic [7:0] o_by [2];

  int total = 0;
  int bad = 0;

  // model: ball state, pending engine writes and tick count
  logic [7:0] mx [2];
  logic [7:0] my [2];
  logic signed [7:0] mdx [2];
  logic signed [7:0] mdy [2];
  int ticks [2];
  bit cdue [2];
  int engn [2];
  logic e_cs [2];
  logic [2:0] e_addr [2];
  logic [7:0] e_data [2];
  logic vprev;

  always #5 clk = ~clk;

  vga_ball_sched u0 (
    .clk(clk), .reset(reset),
    .host_chipselect(cs), .host_write(wr),
    .host_address(addr), .host_writedata(wdata),
    .enable(en), .vga_vs(vs),
    .out_chipselect(o_cs[0]), .out_write(o_wr[0]),
    .out_address(o_addr[0]), .out_writedata(o_data[0]),
    .ball_x(o_bx[0]), .ball_y(o_by[0])
  );

  vga_ball_sched #(.FRAME_DIV(3)) u1 (
    .clk(clk), .reset(reset),
    .host_chipselect(cs), .host_write(wr),
    .host_address(addr), .host_writedata(wdata),
    .enable(en), .vga_vs(vs),
    .out_chipselect(o_cs[1]), .out_write(o_wr[1]),
    .out_address(o_addr[1]), .out_writedata(o_data[1]),
    .ball_x(o_bx[1]), .ball_y(o_by[1])
  );

  function automatic int fdiv(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 8'd80;
      my[k] = 8'd30;
      mdx[k] = 8'sd1;
      mdy[k] = 8'sd1;
      ticks[k] = 0;
      cdue[k] = 1'b0;
      engn[k] = 0;
      e_cs[k] = 1'b0;
      e_addr[k] = 3'd0;
      e_data[k] = 8'd0;
    end
    vprev = 1'b1;
  endtask

  task automatic bounce(input int k);
    int nx, ny;
    nx = int'(mx[k]) + int'(mdx[k]);
    ny = int'(my[k]) + int'(mdy[k]);
    if (nx > XMX) begin
      mx[k] = 8'(XMX); mdx[k] = -mdx[k];
    end else if (nx < XMN) begin
      mx[k] = 8'(XMN); mdx[k] = -mdx[k];
    end else mx[k] = 8'(nx);
    if (ny > YMX) begin
      my[k] = 8'(YMX); mdy[k] = -mdy[k];
    end else if (ny < YMN) begin
      my[k] = 8'(YMN); mdy[k] = -mdy[k];
    end else my[k] = 8'(ny);
  endtask

  // one clock edge of the model, using the inputs held over it
  task automatic model_step();
    bit hw, fw, busy;
    hw = cs & wr;
    fw = hw && (addr <= 3'd4);
    for (int k = 0; k < 2; k++) begin
      busy = cdue[k] || (engn[k] > 0);
      if (hw && addr >= 3'd3 && addr <= 3'd6 && busy) begin
        cdue[k] = 1'b0;
        engn[k] = 0;
      end
      e_cs[k] = 1'b0;
      if (fw) begin
        e_cs[k] = 1'b1;
        e_addr[k] = addr;
        e_data[k] = wdata;
      end else if (engn[k] > 0) begin
        e_cs[k] = 1'b1;
        e_addr[k] = (engn[k] == 2) ? 3'd3 : 3'd4;
        e_data[k] = (engn[k] == 2) ? mx[k] : my[k];
        engn[k]--;
      end
      if (cdue[k]) begin
        bounce(k);
        engn[k] = 2;
        cdue[k] = 1'b0;
      end
      if (hw) begin
        case (addr)
          3'd3: mx[k] = wdata;
          3'd4: my[k] = wdata;
          3'd5: mdx[k] = wdata;
          3'd6: mdy[k] = wdata;
          default: ;
        endcase
      end
      if (vprev && !vs) begin
        ticks[k]++;
        if (ticks[k] % fdiv(k) == 0 && en && !busy)
          cdue[k] = 1'b1;
      end
    end
    vprev = vs;
  endtask

  task automatic check_all(input string step);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_cs%0d", step, k),
          {7'd0, o_cs[k]}, {7'd0, e_cs[k]});
      chk($sformatf("%s_wr%0d", step, k),
          {7'd0, o_wr[k]}, {7'd0, e_cs[k]});
      chk($sformatf("%s_addr%0d", step, k),
          {5'd0, o_addr[k]}, {5'd0, e_addr[k]});
      chk($sformatf("%s_data%0d", step, k),
          o_data[k], e_data[k]);
      chk($sformatf("%s_bx%0d", step, k), o_bx[k], mx[k]);
      chk($sformatf("%s_by%0d", step, k), o_by[k], my[k]);
    end
  endtask

  task automatic cyc(input logic c, input logic w,
                     input logic [2:0] a,
                     input logic [7:0] d,
                     input logic v);
    cs = c; wr = w; addr = a; wdata = d; vs = v;
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
  endtask

  task automatic tickc();
    cyc(1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic host(input logic [2:0] a,
                      input logic [7:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b1);
  endtask

  // reset lands mid-cycle and must clear outputs at once
  task automatic do_reset();
    #2;
    reset = 1'b1;
    cs = 1'b0; wr = 1'b0; vs = 1'b1;
    #1;
    model_reset();
    check_all("rst_now");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ph, len, kind;
    logic [2:0] ra;
    logic [7:0] rd;
    logic rc, rw, rv;

    @(negedge clk);
    do_reset();

    // single frame: 80,30 -> 81,31
    en = 1'b1;
    tickc();
    idle(2);
    chk("t3_addr", {5'd0, o_addr[0]}, 8'd3);
    chk("t3_data", o_data[0], 8'd81);
    idle(1);
    chk("t4_addr", {5'd0, o_addr[0]}, 8'd4);
    chk("t4_data", o_data[0], 8'd31);
    idle(1);
    chk("x1", o_bx[0], 8'd81);
    chk("y1", o_by[0], 8'd31);

    // clamp at X_MAX and reverse dx
    host(3'd3, 8'd155);
    host(3'd5, 8'd3);
    tickc();
    idle(5);
    chk("x_clamp", o_bx[0], 8'd155);
    tickc();
    idle(5);
    chk("x_back", o_bx[0], 8'd152);

    // host burst over the engine write slots
    tickc();
    idle(1);
    repeat (3) host(3'd1, 8'hAA);
    idle(4);

    // frame divider of 3
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      tickc();
      idle(7);
      if (i == 2) chk("div_x2", o_bx[1], 8'd80);
      if (i == 5) chk("div_x5", o_bx[1], 8'd81);
      if (i == 6) chk("div_x6", o_bx[1], 8'd82);
    end
    chk("fd1_x6", o_bx[0], 8'd86);

    // host Y write in WR_X aborts the engine
    tickc();
    idle(1);
    host(3'd4, 8'd10);
    idle(4);
    chk("abort_y", o_by[0], 8'd10);
    chk("abort_y1", o_by[1], 8'd10);

    // reset while the X write is on the bus
    tickc();
    idle(2);
    chk("pre_rst_cs", {7'd0, o_cs[0]}, 8'd1);
    do_reset();
    idle(5);
    chk("rst_x", o_bx[0], 8'd80);
    chk("rst_y", o_by[0], 8'd30);

    // random traffic
    ph = 0;
    len = 12;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 399) == 0) do_reset();
      rv = (ph < 2) ? 1'b0 : 1'b1;
      ph++;
      if (ph >= len) begin
        ph = 0;
        len = $urandom_range(6, 18);
      end
      kind = $urandom_range(0, 7);
      rc = (kind <= 2);
      rw = (kind <= 1) || (kind == 3);
      ra = 3'($urandom_range(0, 7));
      case (ra)
        3'd3: rd = 8'($urandom_range(0, 200));
        3'd4: rd = 8'($urandom_range(0, 80));
        3'd5, 3'd6: rd = 8'($urandom_range(0, 16) - 8);
        default: rd = 8'($urandom_range(0, 255));
      endcase
      cyc(rc, rw, ra, rd, rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_ball_sched.md
# vga_ball_sched

Sequences and shares the vga_ball register write port between the host (HPS/Avalon master) and an on-chip motion engine that bounces the ball once per frame. Host writes are forwarded with priority. The motion engine computes a new position at each vertical-sync start and issues the X/Y register writes in free cycles. It sits between the Avalon bus and the vga_ball slave port, and observes VGA_VS from the same 50 MHz clock domain.

## Interface
- X_MIN, default 4: lowest legal ball X (8-pixel column units).
- X_MAX, default 155: highest legal ball X.
- Y_MIN, default 4: lowest legal ball Y (8-line row units).
- Y_MAX, default 55: highest legal ball Y.
- FRAME_DIV, default 1: motion update every FRAME_DIV frames (1..255).
- clk  in  1  50 MHz system clock.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- host_chipselect  in  1  host select.
- host_write  in  1  host write strobe. Single-cycle accept, never stalled.
- host_address  in  3  0-4 forwarded to vga_ball; 5 = dx, 6 = dy (local); 7 ignored.
- host_writedata  in  8  write data. dx/dy are two's complement.
- enable  in  1  level; 1 = motion engine runs.
- vga_vs  in  1  active-low vertical sync from vga_counters.
- out_chipselect  out  1  to vga_ball chipselect.
- out_write  out  1  to vga_ball write.
- out_address  out  3  to vga_ball address.
- out_writedata  out  8  to vga_ball writedata.
- ball_x  out  8  current internal X.
- ball_y  out  8  current internal Y.

## Operation
- Reset values:
  - out_chipselect = out_write = 0; out_address = 0; out_writedata = 0.
  - x = 80, y = 30, dx = +1, dy = +1.
  - Divider count = 0; vs_q = 1; state IDLE.
- Host path (priority):
  - host_chipselect & host_write & address in 0..4: out_* registered next edge with cs = write = 1, same address and data.
  - Address 3 additionally loads x; address 4 loads y.
  - Address 5 loads dx; 6 loads dy. Neither is forwarded.
  - Any host write to address 3-6 while state is not IDLE aborts the engine to IDLE on that edge. No further engine writes occur for that frame.
- Frame tick: vs_q <= vga_vs each cycle; tick = vs_q & ~vga_vs, i.e. the falling edge of sync.
- Divider: on each tick, if count == FRAME_DIV-1 then count <= 0 and fire = 1; else count <= count+1. The divider runs regardless of enable.
- FSM (IDLE, CALC, WR_X, WR_Y):
  - IDLE -> CALC when fire & enable. A fire in any other state is dropped.
  - CALC -> WR_X, updating x, y, dx, dy (single cycle). Bounce rule, evaluated in 10-bit signed arithmetic:
    - nx = x + sext(dx).
    - If nx > X_MAX: x <= X_MAX, dx <= -dx.
    - Else if nx < X_MIN: x <= X_MIN, dx <= -dx.
    - Else x <= nx.
    - Y uses Y_MIN/Y_MAX the same way.
  - WR_X: if no host write this cycle, drive out_* <= (addr 3, x) and go to WR_Y. Otherwise hold WR_X; the host write wins the port.
  - WR_Y: same, with (addr 4, y), then go to IDLE.
  - enable deasserted mid-sequence does not abort. The current frame completes.
- Any cycle with neither a host nor an engine write: out_chipselect = out_write = 0; address and data hold their last values.
- -128 negation: dx = -128 negates to -128 (wraps); this is accepted as is. Software keeps |dx|, |dy| <= 8.

## Timing
- Host write accepted in cycle C -> appears on out_* in cycle C+1 (one-cycle latency, no backpressure).
- Tick in cycle T, no host activity:
  - T+1: CALC.
  - T+2: WR_X; ball_x/ball_y show new values.
  - T+3: out_write = 1, address 3, new x.
  - T+4: out_write = 1, address 4, new y.
  - T+5: idle.
- Each host write colliding with WR_X/WR_Y delays the engine write by exactly one cycle per colliding cycle.
- At most one out_write per cycle. Engine writes never reorder: X always precedes Y.
- Asynchronous reset mid-sequence forces IDLE and all reset values immediately; no partial write completes after reset deassertion.

## Test plan
- Reset, then one vga_vs falling edge with enable = 1 -> cycle T+3: out addr 3 = 81; T+4: addr 4 = 31; ball_x = 81, ball_y = 31.
- Host writes addr 3 = 155, addr 5 = 0x03, then a tick -> out addr 3 = 155 (clamped), dx reads back as -3 on the next frame: x = 152.
- Host writes addr 1 = 0xAA continuously across T+2..T+4 -> host writes appear every cycle; engine X/Y writes follow immediately after the host burst ends, in order.
- FRAME_DIV = 3, five ticks with enable = 1 -> exactly one motion update (on the 3rd tick); the 6th tick gives the second update.
- Host write to addr 4 = 10 in cycle T+2 -> engine aborts; out shows only (4, 10); no engine writes that frame; y = 10.
- Assert reset in cycle T+3 -> all out_* = 0 immediately; x = 80, y = 30 after release; no write to addr 4 occurs.
